// File: rtl/load_store_unit.sv
// Load/store front end for memory_controller: sizes, aligns and lane-shifts core
// requests into one CYC/ACK bus transaction at a time, and extends load results.
module load_store_unit #(
    parameter int DATA_SIZE = 64,
    parameter int ADDR_SIZE = 64
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [2:0]           funct3,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 fault,
    output logic                 CYC_O,
    output logic                 WE_O,
    output logic [7:0]           SEL_O,
    output logic [ADDR_SIZE-1:0] ADR_O,
    output logic [DATA_SIZE-1:0] DAT_O,
    input  logic [DATA_SIZE-1:0] DAT_I,
    input  logic                 ACK_I
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, FLT} state_t;

    state_t     state, state_next;
    logic       req, legal, is_store;
    logic [2:0] f3_q, off_q;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // raw is already shifted down so the addressed byte sits in lane 0
    function automatic logic [DATA_SIZE-1:0] extend(input logic [DATA_SIZE-1:0] raw,
                                                    input logic [2:0] f3);
        logic [DATA_SIZE-1:0] r;
        case (f3)
            3'b000:  r = {{56{raw[7]}}, raw[7:0]};
            3'b001:  r = {{48{raw[15]}}, raw[15:0]};
            3'b010:  r = {{32{raw[31]}}, raw[31:0]};
            3'b100:  r = {56'b0, raw[7:0]};
            3'b101:  r = {48'b0, raw[15:0]};
            3'b110:  r = {32'b0, raw[31:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    assign req = rd_en | wr_en;

    always_comb begin
        legal = 1'b1;
        case (funct3)
            3'b111:        legal = 1'b0;
            3'b001, 3'b101: legal = ~addr[0];
            3'b010, 3'b110: legal = (addr[1:0] == 2'b00);
            3'b011:        legal = (addr[2:0] == 3'b000);
            default:       legal = 1'b1;
        endcase
        // there is no zero-extending store
        if (wr_en && funct3[2])
            legal = 1'b0;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = legal ? WAIT : FLT;
            WAIT:    if (ACK_I) state_next = DONE;
            DONE:    state_next = IDLE;
            FLT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            rd_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
            CYC_O    <= 1'b0;
            WE_O     <= 1'b0;
            SEL_O    <= '0;
            ADR_O    <= '0;
            DAT_O    <= '0;
            is_store <= 1'b0;
            f3_q     <= '0;
            off_q    <= '0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && legal) begin
                        is_store <= wr_en;
                        f3_q     <= funct3;
                        off_q    <= addr[2:0];
                        busy     <= 1'b1;
                        CYC_O    <= 1'b1;
                        WE_O     <= wr_en;
                        SEL_O    <= size_mask(funct3[1:0]) << addr[2:0];
                        ADR_O    <= {addr[ADDR_SIZE-1:3], 3'b000};
                        DAT_O    <= wr_data << {addr[2:0], 3'b000};
                    end else if (req) begin
                        fault <= 1'b1;
                    end
                end
                WAIT: begin
                    if (ACK_I) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        CYC_O <= 1'b0;
                        WE_O  <= 1'b0;
                        SEL_O <= '0;
                        if (!is_store)
                            rd_data <= extend(DAT_I >> {off_q, 3'b000}, f3_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: stimulus pushes expected
// responses, a negedge monitor checks bus phases and done/fault pulses.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [63:0] addr = '0, wr_data = '0, dat_i = '0;
    logic        ack = 1'b0;
    logic [63:0] rd_data, adr_o, dat_o;
    logic        busy, done, fault, cyc_o, we_o;
    logic [7:0]  sel_o;

    always #5 clk = ~clk;

    load_store_unit dut (
        .CLK_I(clk), .RST_I(rst), .rd_en(rd_en), .wr_en(wr_en), .funct3(funct3),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .done(done),
        .fault(fault), .CYC_O(cyc_o), .WE_O(we_o), .SEL_O(sel_o), .ADR_O(adr_o),
        .DAT_O(dat_o), .DAT_I(dat_i), .ACK_I(ack)
    );

    typedef struct {
        bit          flt;
        bit          we;
        logic [7:0]  sel;
        logic [63:0] adr;
        logic [63:0] dat;
        logic [63:0] rd;
        int          busy;
    } exp_t;

    exp_t        q[$];
    logic [63:0] model_rd = '0;
    int          total = 0, bad = 0;
    int          done_cnt = 0, fault_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: byte-granular view of the access, derived from size/offset rules
    task automatic model(input bit re, input bit we, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input logic [63:0] di, input int k, output exp_t e);
        int n, off;
        logic [63:0] v;
        n   = 1 << f3[1:0];
        off = int'(a % 8);
        e.we  = we;
        e.flt = (f3 == 3'd7) || (a % n != 0) || (we && f3 >= 3'd4) || !(re || we);
        e.adr = a - 64'(off);
        e.sel = '0;
        e.dat = '0;
        for (int b = 0; b < n; b++)
            if (off + b < 8) e.sel[off + b] = 1'b1;
        for (int b = 0; b + off < 8; b++)
            e.dat[8*(b+off) +: 8] = wd[8*b +: 8];
        e.busy = e.flt ? 0 : k + 1;
        if (!e.flt && !we) begin
            v = '0;
            for (int b = 0; b < n; b++)
                v[8*b +: 8] = di[8*(off+b) +: 8];
            if (!f3[2] && n < 8 && v[8*n-1])
                for (int b = n; b < 8; b++) v[8*b +: 8] = 8'hFF;
            model_rd = v;
        end
        e.rd = model_rd;
    endtask

    task automatic issue(input bit re, input bit we, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input logic [63:0] di, input int k);
        exp_t e;
        model(re, we, f3, a, wd, di, k, e);
        q.push_back(e);
        @(posedge clk); #1;
        rd_en = re; wr_en = we; funct3 = f3; addr = a; wr_data = wd;
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
        if (!e.flt) begin
            repeat (k) begin @(posedge clk); #1; end
            dat_i = di; ack = 1'b1;
            @(posedge clk); #1;
            ack = 1'b0; dat_i = {$urandom, $urandom};
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // Monitor: every cycle of a bus phase and every completion pulse is checked
    initial begin
        int   busy_cnt;
        bit   cyc_seen;
        exp_t e;
        busy_cnt = 0;
        cyc_seen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
                cyc_seen = 0;
                continue;
            end
            if (busy) busy_cnt++;
            if (cyc_o) begin
                cyc_seen = 1;
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL cyc_unexpected actual=CYC_O=1 required=CYC_O=0");
                end else begin
                    chk("sel", 64'(sel_o), 64'(q[0].sel));
                    chk("adr", adr_o, q[0].adr);
                    chk("we", 64'(we_o), 64'(q[0].we));
                    chk("dat_o", dat_o, q[0].dat);
                end
            end
            if (done || fault) begin
                if (done) done_cnt++;
                if (fault) fault_cnt++;
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL resp_unexpected actual=done%0b/fault%0b required=none", done, fault);
                end else begin
                    e = q.pop_front();
                    chk("fault_kind", 64'(fault), 64'(e.flt));
                    chk("done_kind", 64'(done), 64'(!e.flt));
                    chk("rd_data", rd_data, e.rd);
                    chk("bus_used", 64'(cyc_seen), 64'(!e.flt));
                    chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
                end
                busy_cnt = 0;
                cyc_seen = 0;
            end
        end
    end

    initial begin
        int dc, fc, op, n;
        logic [2:0]  f3;
        logic [63:0] a;
        exp_t        e;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", 64'(cyc_o), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_sel", 64'(sel_o), 0);
        chk("rst_done_fault", 64'({done, fault}), 0);
        rst = 1'b0;

        // directed loads/stores
        issue(1, 0, 3'b011, 64'h1000008, 64'h0, 64'h8877665544332211, 31);
        issue(1, 0, 3'b000, 64'h1000003, 64'h0, 64'h00000000F0000000, 2);
        issue(1, 0, 3'b100, 64'h1000003, 64'h0, 64'h00000000F0000000, 0);
        issue(1, 0, 3'b010, 64'h1000004, 64'h0, 64'h8000000100000000, 1);
        issue(1, 0, 3'b110, 64'h1000004, 64'h0, 64'h8000000100000000, 3);
        issue(0, 1, 3'b001, 64'h1000006, 64'hABCD, 64'h1234, 2);

        // illegal requests
        issue(0, 1, 3'b010, 64'h1000002, 64'h55, 64'h0, 0);
        issue(1, 0, 3'b111, 64'h1000000, 64'h0, 64'h0, 0);
        issue(0, 1, 3'b100, 64'h1000000, 64'h77, 64'h0, 0);

        // randomized mix
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            f3 = 3'($urandom_range(0, 7));
            a  = 64'h2000000 + 64'($urandom_range(0, 255));
            if ($urandom_range(0, 2) != 0) begin
                n = 1 << f3[1:0];
                a = a - (a % n);
            end
            issue(op != 1, op != 0, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 5));
        end

        // both enables: store wins
        issue(1, 1, 3'b011, 64'h3000000, 64'hCAFEF00D12345678, 64'hFFFF, 1);

        // ACK in IDLE
        dc = done_cnt; fc = fault_cnt;
        ack = 1'b1; dat_i = 64'hDEAD;
        @(posedge clk); #1;
        ack = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("idle_ack_done", 64'(done_cnt), 64'(dc));
        chk("idle_ack_busy", 64'(busy), 0);

        // load rd_data with something non-zero, then reset mid-WAIT
        issue(1, 0, 3'b011, 64'h4000000, 64'h0, 64'h0123456789ABCDEF, 0);
        model(1, 0, 3'b011, 64'h4000010, 64'h0, 64'h0, 0, e);
        q.push_back(e);
        @(posedge clk); #1;
        rd_en = 1'b1; funct3 = 3'b011; addr = 64'h4000010;
        @(posedge clk); #1;
        rd_en = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("arst_cyc", 64'(cyc_o), 0);
        chk("arst_busy", 64'(busy), 0);
        chk("arst_sel_we", 64'({sel_o, we_o}), 0);
        chk("arst_adr", adr_o, 0);
        chk("arst_dat_o", dat_o, 0);
        chk("arst_rd_data", rd_data, 0);
        q.delete();
        model_rd = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // late ACK after reset is ignored
        dc = done_cnt;
        dat_i = 64'hFFFFFFFFFFFFFFFF; ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("late_ack_done", 64'(done_cnt), 64'(dc));
        chk("late_ack_rd", rd_data, 0);
        chk("late_ack_cyc", 64'(cyc_o), 0);

        // unit still works after reset
        issue(1, 0, 3'b101, 64'h5000002, 64'h0, 64'h00000000BEEF0000, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
